// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: FSM states, operation codes, ALU opcodes.
// MULDIV_SIGNED_EN enables the ABS/NEG states used for signed operation.
package alu_muldiv_sequencer_pkg;

  localparam logic [3:0]  DefaultAddOpx = 4'h1;
  localparam logic [3:0]  DefaultSubOpx = 4'h2;
  localparam int unsigned DefaultSteps  = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StZdiv = 3'd2,
    StFin  = 3'd3,
    StAbs  = 3'd4,
    StNeg  = 3'd5
  } state_e;

  typedef enum logic {
    OpMul = 1'b0,
    OpDiv = 1'b1
  } op_e;

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// Command, result and shared-ALU handshake signals of the multiply/divide sequencer.
// MULDIV_SIGNED_EN adds the signed_op command bit.
interface alu_muldiv_sequencer_if;
  logic        start;
  logic        op;
  logic [15:0] opa;
  logic [15:0] opb;
`ifdef MULDIV_SIGNED_EN
  logic        signed_op;
`endif
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        div_zero;
  logic        alu_req;
  logic        alu_gnt;
  logic [3:0]  seq_alu_opx;
  logic [15:0] seq_alua;
  logic [15:0] seq_alub;
  logic [15:0] alu_r;
  logic        alu_carry;

`ifdef MULDIV_SIGNED_EN
  modport slave (
    input  start, op, opa, opb, signed_op, alu_gnt, alu_r, alu_carry,
    output busy, done, result_lo, result_hi, div_zero, alu_req, seq_alu_opx, seq_alua, seq_alub
  );
  modport master (
    output start, op, opa, opb, signed_op, alu_gnt, alu_r, alu_carry,
    input  busy, done, result_lo, result_hi, div_zero, alu_req, seq_alu_opx, seq_alua, seq_alub
  );
`else
  modport slave (
    input  start, op, opa, opb, alu_gnt, alu_r, alu_carry,
    output busy, done, result_lo, result_hi, div_zero, alu_req, seq_alu_opx, seq_alua, seq_alub
  );
  modport master (
    output start, op, opa, opb, alu_gnt, alu_r, alu_carry,
    input  busy, done, result_lo, result_hi, div_zero, alu_req, seq_alu_opx, seq_alua, seq_alub
  );
`endif
endinterface

// File: rtl/alu_muldiv_sequencer_step.sv
// Combinational next-H/L logic for one shift-and-add multiply step or one restoring divide step.
// The ALU sum/difference and raw carry/borrow arrive from outside in the same cycle.
module muldiv_step_datapath (
  input  logic        op_div_i,
  input  logic [15:0] h_i,
  input  logic [15:0] l_i,
  input  logic [15:0] alu_r_i,
  input  logic        alu_carry_i,
  output logic [15:0] alu_a_o,
  output logic [15:0] h_o,
  output logic [15:0] l_o
);

  logic [15:0] shifted;
  logic        q;

  always_comb begin
    shifted = {h_i[14:0], l_i[15]};
    // A set top bit means the shifted partial remainder already exceeds any 16-bit divisor.
    q       = h_i[15] | ~alu_carry_i;
    if (op_div_i) begin
      alu_a_o = shifted;
      h_o     = q ? alu_r_i : shifted;
      l_o     = {l_i[14:0], q};
    end else begin
      alu_a_o = h_i;
      if (l_i[0]) begin
        h_o = {alu_carry_i, alu_r_i[15:1]};
        l_o = {alu_r_i[0], l_i[15:1]};
      end else begin
        h_o = {1'b0, h_i[15:1]};
        l_o = {h_i[0], l_i[15:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 divide sequencer borrowing the shared ALU via REQ/GNT.
// Define MULDIV_SIGNED_EN for signed operation (ABS before RUN, NEG after it).
module alu_muldiv_sequencer
  import alu_muldiv_sequencer_pkg::*;
#(
  parameter logic [3:0]  AddOpx = DefaultAddOpx,
  parameter logic [3:0]  SubOpx = DefaultSubOpx,
  parameter int unsigned Steps  = DefaultSteps
) (
  input logic                   clk,
  input logic                   reset,
  alu_muldiv_sequencer_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(Steps + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [15:0]     h_q, h_d, l_q, l_d, m_q, m_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            div_zero_q, div_zero_d;
  logic [15:0]     res_hi_q, res_lo_q;

  logic            alu_req;
  logic [3:0]      alu_opx;
  logic [15:0]     alu_a, alu_b;
  logic [15:0]     step_alu_a, step_h, step_l;

`ifdef MULDIV_SIGNED_EN
  logic signed_q, signed_d;
  logic sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
  logic neg_phase_q, neg_phase_d;
  logic borrow_q, borrow_d;
  logic neg_lo, neg_hi;

  assign neg_lo = sgn_a_q ^ sgn_b_q;
  assign neg_hi = (op_q == OpDiv) ? sgn_a_q : (sgn_a_q ^ sgn_b_q);
`endif

  muldiv_step_datapath u_step (
    .op_div_i    (op_q == OpDiv),
    .h_i         (h_q),
    .l_i         (l_q),
    .alu_r_i     (bus.alu_r),
    .alu_carry_i (bus.alu_carry),
    .alu_a_o     (step_alu_a),
    .h_o         (step_h),
    .l_o         (step_l)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    h_d        = h_q;
    l_d        = l_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    alu_req    = 1'b0;
    alu_opx    = '0;
    alu_a      = '0;
    alu_b      = '0;
`ifdef MULDIV_SIGNED_EN
    signed_d    = signed_q;
    sgn_a_d     = sgn_a_q;
    sgn_b_d     = sgn_b_q;
    neg_phase_d = neg_phase_q;
    borrow_d    = borrow_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          h_d        = '0;
          l_d        = bus.opa;
          m_d        = bus.opb;
          cnt_d      = '0;
          op_d       = op_e'(bus.op);
          div_zero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
          signed_d = bus.signed_op;
          sgn_a_d  = bus.signed_op & bus.opa[15];
          sgn_b_d  = bus.signed_op & bus.opb[15];
`endif
          if ((op_e'(bus.op) == OpDiv) && (bus.opb == '0)) begin
            state_d = StZdiv;
`ifdef MULDIV_SIGNED_EN
          end else if (bus.signed_op) begin
            state_d = StAbs;
`endif
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        alu_req = 1'b1;
        alu_opx = (op_q == OpDiv) ? SubOpx : AddOpx;
        alu_a   = step_alu_a;
        alu_b   = m_q;
        if (bus.alu_gnt) begin
          h_d   = step_h;
          l_d   = step_l;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StFin;
`ifdef MULDIV_SIGNED_EN
            if (signed_q && neg_lo) begin
              state_d     = StNeg;
              neg_phase_d = 1'b0;
              borrow_d    = 1'b0;
            end else if (signed_q && neg_hi) begin
              state_d     = StNeg;
              neg_phase_d = 1'b1;
              borrow_d    = 1'b0;
            end
`endif
          end
        end
      end
      StZdiv: begin
        h_d        = l_q;
        l_d        = '1;
        div_zero_d = 1'b1;
        state_d    = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
`ifdef MULDIV_SIGNED_EN
      StAbs: begin
        // The ALU forms |A| as 0-A; |B| is negated locally so ABS costs a single cycle.
        alu_req = 1'b1;
        alu_opx = SubOpx;
        alu_b   = l_q;
        if (bus.alu_gnt) begin
          if (sgn_a_q) l_d = bus.alu_r;
          if (sgn_b_q) m_d = ~m_q + 16'd1;
          state_d = StRun;
        end
      end
      StNeg: begin
        alu_req = 1'b1;
        alu_opx = SubOpx;
        if (!neg_phase_q) begin
          alu_b = l_q;
          if (bus.alu_gnt) begin
            l_d      = bus.alu_r;
            borrow_d = (op_q == OpMul) & bus.alu_carry;
            if (neg_hi) neg_phase_d = 1'b1;
            else        state_d     = StFin;
          end
        end else begin
          // 0-H-borrow is formed as 16'hFFFF-H when the low half borrowed.
          alu_a = borrow_q ? 16'hFFFF : 16'h0000;
          alu_b = h_q;
          if (bus.alu_gnt) begin
            h_d     = bus.alu_r;
            state_d = StFin;
          end
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpMul;
      h_q        <= '0;
      l_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
`ifdef MULDIV_SIGNED_EN
      signed_q    <= 1'b0;
      sgn_a_q     <= 1'b0;
      sgn_b_q     <= 1'b0;
      neg_phase_q <= 1'b0;
      borrow_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      h_q        <= h_d;
      l_q        <= l_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
      // FIN always falls back to IDLE, so this only fires on the FIN entry edge.
      if (state_d == StFin) begin
        res_hi_q <= h_d;
        res_lo_q <= l_d;
      end
`ifdef MULDIV_SIGNED_EN
      signed_q    <= signed_d;
      sgn_a_q     <= sgn_a_d;
      sgn_b_q     <= sgn_b_d;
      neg_phase_q <= neg_phase_d;
      borrow_q    <= borrow_d;
`endif
    end
  end

  assign bus.busy        = (state_q != StIdle) && (state_q != StFin);
  assign bus.done        = (state_q == StFin);
  assign bus.result_lo   = res_lo_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.div_zero    = div_zero_q;
  assign bus.alu_req     = alu_req;
  assign bus.seq_alu_opx = alu_opx;
  assign bus.seq_alua    = alu_a;
  assign bus.seq_alub    = alu_b;

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Multi-cycle sequencer that borrows the shared 16-bit ALU to run unsigned 16x16->32 multiply (shift-and-add) and 16/16 divide (restoring).
- Sits beside the instruction decoder and requests the ALU through a REQ/GNT handshake.
- While granted, it drives the ALU opcode and both operand buses and consumes the ALU result and raw carry.
- Owns its partial-product/remainder registers and presents a 32-bit result with a one-cycle DONE pulse.

Parameters:
ADD_OPX, 4'h1, ALU opcode for A+B; raw carry = carry-out.
SUB_OPX, 4'h2, ALU opcode for A-B; raw carry = borrow (1 when A<B unsigned).
STEPS, 16, iteration count; equals operand width.

Ports:
CLK  in  1  system clock, all state updates on rising edge
RESET  in  1  synchronous, active-high
START  in  1  begin operation; sampled only in IDLE
OP  in  1  0=MUL, 1=DIV
OPA  in  16  multiplicand / dividend
OPB  in  16  multiplier / divisor
BUSY  out  1  operation in progress
DONE  out  1  one-cycle pulse; results valid
RESULT_LO  out  16  MUL: product[15:0]; DIV: quotient
RESULT_HI  out  16  MUL: product[31:16]; DIV: remainder
DIV_ZERO  out  1  last DIV had OPB==0; held until next START
ALU_REQ  out  1  sequencer wants the ALU this cycle
ALU_GNT  in  1  arbiter grant; step executes only when REQ&GNT
SEQ_ALU_OPX  out  4  opcode to ALU (ADD_OPX/SUB_OPX; 0 when not REQ)
SEQ_ALUA  out  16  ALU operand A
SEQ_ALUB  out  16  ALU operand B
ALU_R  in  16  ALU result, combinational, same cycle
ALU_CARRY  in  1  unlatched ALU carry/borrow, same cycle

Behaviour:
- Reset: state IDLE; BUSY=0, DONE=0, ALU_REQ=0, DIV_ZERO=0, RESULT_*=0, step counter=0. Reset mid-operation aborts with no DONE.
- States: IDLE -> RUN (START, OPB!=0 or MUL) | ZDIV (START, DIV, OPB==0); RUN -> FIN after STEPS granted steps; ZDIV -> FIN; FIN -> IDLE.
- IDLE: START loads H=0, L=OPA, M=OPB, cnt=0, clears DIV_ZERO. START is ignored in every other state.
- RUN: BUSY=1, ALU_REQ=1.
  - Cycle without GNT: registers hold, no step consumed.
  - Granted cycle: one step executes and cnt increments. FIN is entered on the edge where cnt==STEPS-1 is granted.
- MUL step: SEQ_ALUA=H, SEQ_ALUB=M, OPX=ADD_OPX.
  - If L[0]: {H,L} <= {ALU_CARRY,ALU_R,L[15:1]}.
  - Else: {H,L} <= {1'b0,H,L[15:1]}.
- DIV step: S={H[14:0],L[15]}, top=H[15]; SEQ_ALUA=S, SEQ_ALUB=M, OPX=SUB_OPX; q=top|~ALU_CARRY.
  - H <= q ? ALU_R : S.
  - L <= {L[14:0],q}.
- ZDIV: one cycle; H=OPA (remainder), L=16'hFFFF; DIV_ZERO<=1; no ALU request.
- FIN: RESULT_HI<=H, RESULT_LO<=L registered at the FIN entry edge; DONE=1 and BUSY=0 for exactly one cycle.
- Latency with continuous grant: START sampled at edge k -> DONE high in the cycle after edge k+16. ZDIV: DONE in the cycle after edge k+1.
- Results and DIV_ZERO hold until the next accepted START.
- SEQ_ALUA/B are 0 when not in RUN.
- Arbiter keeps CCL_LD inactive for decoder-issued ops while GNT is asserted; this block never loads the CC latch.

Optional Feature:
- Macro MULDIV_SIGNED_EN adds input SIGNED (1 bit, sampled with START) and states ABS and NEG.
- When SIGNED=1:
  - ABS (1 cycle, uses ALU SUB 0-x) replaces negative operands by magnitude before RUN.
  - NEG (1-2 cycles) after RUN negates the product (32-bit, two ALU ops with borrow chain) if sign(A)^sign(B).
  - For DIV, NEG negates the quotient if signs differ and the remainder if OPA<0.
  - -32768/-1 wraps to quotient 16'h8000, remainder 0.
- Without the macro, or with SIGNED=0, timing and results are exactly the unsigned behaviour above.

Decomposition:
- Shared constants package: state encodings (IDLE, RUN, ZDIV, FIN, ABS, NEG), OP encodings, default ADD/SUB opcodes.
- One natural sub-module: muldiv_step_datapath, the combinational next-H/L/q logic for the MUL and DIV steps. The FSM, counter and handshake stay in the top module.

Test Plan:
- MUL 0x1234*0x5678, GNT tied 1 -> DONE 17 cycles after START; HI=0x0626, LO=0x0060.
- MUL 0xFFFF*0xFFFF -> HI=0xFFFE, LO=0x0001; then DIV 1000/7 -> LO=0x008E, HI=0x0006, DIV_ZERO=0.
- DIV 0x1234/0 -> no ALU_REQ; DONE two cycles after START; LO=0xFFFF, HI=0x1234, DIV_ZERO=1.
- DIV 0xFFFF/0x0001 with GNT low on alternate cycles -> DONE after 16 granted steps (~33 cycles); LO=0xFFFF, HI=0.
- START pulsed while BUSY, then RESET asserted mid-RUN -> second START ignored; after reset BUSY=0, no DONE, RESULT_*=0.
- MULDIV_SIGNED_EN: -7*3 -> 0xFFFF_FFEB; -7/2 -> LO=0xFFFD, HI=0xFFFF; SIGNED=0 on the same operands matches unsigned results.
